// File: rtl/uart_rx_oversampled_fifo_pkg.sv
// uart_pkg
// Shared definitions for the oversampled UART receive path:
//   - uart_state_t     : receiver FSM states
//   - OVS_RATE         : oversample ticks per bit
//   - SAMPLE_LO/MID/HI : oversample counts at which the line is sampled
//   - DATA_BITS        : payload bits per 8N1 frame
//   - uart_ovs_div()   : clk cycles per oversample tick, rounded to nearest
//   - uart_maj3()      : 2-of-3 majority vote
// No ports (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int OVS_RATE   = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    // Adding baud*8 (half of baud*16) before dividing rounds to nearest.
    // Clamped to 1 so a very fast baud still yields a usable tick.
    function automatic int uart_ovs_div(input int clk_mhz, input int baud);
        int div;
        div = (clk_mhz * 1000000 + baud * 8) / (baud * 16);
        return (div < 1) ? 1 : div;
    endfunction

    function automatic logic uart_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_fifo_if.sv
// uart_rx_oversampled_fifo_if
// Register-layer side of the UART receiver: pop handshake, flush and status.
//   clear      : one-cycle flush of FIFO and sticky flags (register layer -> rx)
//   rd_en      : pop the head entry (register layer -> rx)
//   rx_data    : FIFO head, first-word-fall-through, 0 when empty
//   rx_ready   : FIFO not empty
//   fifo_count : occupancy, 0..FIFO_DEPTH
//   frame_err  : sticky, a stop bit was sampled low
//   overrun    : sticky, a byte arrived while the FIFO was full
// Modports: master = register layer, slave = receiver.
interface uart_rx_oversampled_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 clear;
    logic                 rd_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic [CW-1:0]        fifo_count;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output clear, rd_en,
        input  rx_data, rx_ready, fifo_count, frame_err, overrun
    );

    modport slave (
        input  clear, rd_en,
        output rx_data, rx_ready, fifo_count, frame_err, overrun
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// First-word-fall-through synchronous FIFO with wrap-around pointers.
//   clk, rst : clock, synchronous active-high reset
//   clear    : flush to empty (takes priority over push/pop)
//   push/din : write din when not full, or when full and a pop happens too
//   pop      : discard head entry; ignored when empty
//   dout     : head entry, 0 when empty
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on an empty FIFO has nothing to remove, so a simultaneous push
    // into an empty FIFO is a plain push. When full, a real pop frees the
    // slot the push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array has no reset; only entries between the pointers are
    // ever visible.
    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled_fifo.sv
// uart_rx_oversampled_fifo
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority voting at
// oversample counts 7/8/9, and a FWFT receive FIFO with sticky
// framing/overrun flags.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   rx_enable : low forces the receiver FSM to IDLE
//   bus       : register-layer interface (clear, rd_en, rx_data, rx_ready,
//               fifo_count, frame_err, overrun)
// Timing: the count-9 sample is registered with the vote, the FSM acts on it
// the next cycle, the byte is pushed the cycle after that and rx_ready rises
// one cycle later, i.e. 3 clk after the count-9 cycle of the stop bit.
module uart_rx_oversampled_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 115200,
    parameter int CLK_VAL_MHZ = 50,
    parameter int FIFO_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        rx_enable,
    uart_rx_oversampled_fifo_if.slave   bus
);

    localparam int          OVS_DIV  = uart_ovs_div(CLK_VAL_MHZ, BAUD_RATE);
    localparam logic [15:0] DIV_LAST = 16'(OVS_DIV - 1);
    localparam logic [3:0]  CNT_LO   = 4'(SAMPLE_LO);
    localparam logic [3:0]  CNT_MID  = 4'(SAMPLE_MID);
    localparam logic [3:0]  CNT_HI   = 4'(SAMPLE_HI);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic                  rx_s1;
    logic                  rx_s2;
    logic                  rx_d;

    logic [15:0]           div_cnt;
    logic [3:0]            ovs_cnt;
    logic                  tick;

    logic                  samp_lo;
    logic                  samp_mid;
    logic                  bit_val;
    logic                  bit_strobe;

    uart_state_t           state;
    uart_state_t           state_next;
    logic                  shift_en;
    logic                  clr_idx;
    logic                  push_req;
    logic                  set_ferr;

    logic [2:0]            bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  push_q;
    logic [FIFO_WIDTH-1:0] push_data;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  overflow;

    // Two-flop synchroniser plus one extra stage for falling-edge detection.
    // Preset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Oversample tick generator. Held at zero in IDLE, so counting starts
    // from the falling edge that moves the FSM into START.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            ovs_cnt <= ovs_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Line sampling. The third sample and the vote are registered together,
    // producing a one-cycle strobe the FSM consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_lo    <= 1'b1;
            samp_mid   <= 1'b1;
            bit_val    <= 1'b1;
            bit_strobe <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            if (state != IDLE && tick) begin
                case (ovs_cnt)
                    CNT_LO:  samp_lo <= rx_s2;
                    CNT_MID: samp_mid <= rx_s2;
                    CNT_HI: begin
                        bit_val    <= uart_maj3(samp_lo, samp_mid, rx_s2);
                        bit_strobe <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and control strobes. Dropping rx_enable overrides
    // everything, discarding any partial byte without raising a flag.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        clr_idx    = 1'b0;
        push_req   = 1'b0;
        set_ferr   = 1'b0;
        if (!rx_enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s2) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (bit_strobe) begin
                        if (!bit_val) begin
                            state_next = DATA;
                            clr_idx    = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        shift_en = 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_strobe) begin
                        if (bit_val) begin
                            push_req   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            set_ferr   = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s2) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Receive shift register (LSB first) and the registered push toward the
    // FIFO, which lands the cycle after the stop-bit decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx   <= '0;
            shift_reg <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            push_q <= push_req;
            if (push_req) begin
                push_data <= FIFO_WIDTH'(shift_reg);
            end
            if (clr_idx) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.clear),
        .push  (push_q),
        .pop   (bus.rd_en),
        .din   (push_data),
        .dout  (bus.rx_data),
        .count (bus.fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rx_ready = !fifo_empty;

    // A full FIFO only rejects the byte when no pop frees a slot that cycle.
    assign overflow = push_q && fifo_full && !bus.rd_en;

    // Sticky flags; clear wins over a coincident set.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (bus.clear) begin
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            if (set_ferr) begin
                bus.frame_err <= 1'b1;
            end
            if (overflow) begin
                bus.overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled_fifo.sv
// tb_uart_rx_oversampled_fifo
// Self-checking bench for uart_rx_oversampled_fifo at 1 MHz / 62500 baud,
// giving one oversample tick per clk and 16 clk per bit. Inputs change 1 ns
// after each rising edge; outputs are read at the same point.
`timescale 1ns/1ps
module tb_uart_rx_oversampled_fifo;

    localparam int CLK_MHZ  = 1;
    localparam int BAUD     = 62500;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 16;

    typedef struct {
        logic [7:0] tx_byte;
        logic       glitch;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic rx_enable;

    int checks = 0;
    int errors = 0;

    vec_t vecs[6];

    uart_rx_oversampled_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_oversampled_fifo #(
        .BAUD_RATE   (BAUD),
        .CLK_VAL_MHZ (CLK_MHZ),
        .FIFO_WIDTH  (8),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_enable (rx_enable),
        .bus       (bus)
    );

    always #500 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one 8N1 frame. glitch inverts one clk per data bit at line offset
    // 8, 9 or 10 (each hits exactly one of the three votes). disable_at >= 0
    // drops rx_enable at the start of that data bit and leaves it low.
    task automatic applyStimulus(input logic [7:0] data, input int stop_len, input logic stop_val,
                                 input logic glitch, input int disable_at);
        logic v;
        int   len;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop_val;
            else             v = data[k-1];
            len = (k == 9) ? stop_len : BIT_CLKS;
            for (int off = 0; off < len; off++) begin
                if (disable_at >= 0 && k == disable_at + 1 && off == 0) rx_enable = 1'b0;
                if (glitch && k >= 1 && k <= 8 && off == 8 + ((k - 1) % 3)) rx = ~v;
                else rx = v;
                tick(1);
            end
        end
        rx = 1'b1;
    endtask

    task automatic popOne();
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulseClear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        #20ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 1'b0, 8'hFF};
        vecs[2] = '{8'h7E, 1'b0, 8'h7E};
        vecs[3] = '{8'hC3, 1'b1, 8'hC3};
        vecs[4] = '{8'h5A, 1'b1, 8'h5A};
        vecs[5] = '{8'h96, 1'b0, 8'h96};

        rst       = 1'b1;
        rx        = 1'b1;
        rx_enable = 1'b1;
        bus.clear = 1'b0;
        bus.rd_en = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        checkOutput("reset_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("reset_data", 32'(bus.rx_data), 32'h0);
        checkOutput("reset_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("reset_ferr", 32'(bus.frame_err), 32'd0);
        checkOutput("reset_ovr", 32'(bus.overrun), 32'd0);

        // 0xA5: stop-bit count 9 is clk 156 after the start edge, so rx_ready
        // must be low at clk 158 and high at clk 159.
        $display("[TB] latency frame 0xA5");
        applyStimulus(8'hA5, 14, 1'b1, 1'b0, -1);
        checkOutput("a5_ready_early", 32'(bus.rx_ready), 32'd0);
        tick(1);
        checkOutput("a5_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("a5_data", 32'(bus.rx_data), 32'hA5);
        checkOutput("a5_count", 32'(bus.fifo_count), 32'd1);
        tick(2);
        popOne();
        checkOutput("a5_pop_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("a5_pop_data", 32'(bus.rx_data), 32'h0);

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].tx_byte, BIT_CLKS, 1'b1, vecs[i].glitch, -1);
            tick(4);
            checkOutput($sformatf("vec%0d_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'd1);
            checkOutput($sformatf("vec%0d_ferr", i), 32'(bus.frame_err), 32'd0);
            popOne();
            checkOutput($sformatf("vec%0d_empty", i), 32'(bus.fifo_count), 32'd0);
        end

        $display("[TB] start glitch rejection");
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        checkOutput("glitch_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("glitch_ferr", 32'(bus.frame_err), 32'd0);
        checkOutput("glitch_ovr", 32'(bus.overrun), 32'd0);
        applyStimulus(8'h3C, BIT_CLKS, 1'b1, 1'b0, -1);
        tick(4);
        checkOutput("post_glitch_data", 32'(bus.rx_data), 32'h3C);
        checkOutput("post_glitch_count", 32'(bus.fifo_count), 32'd1);
        popOne();

        $display("[TB] framing error");
        applyStimulus(8'h55, 40, 1'b0, 1'b0, -1);
        tick(20);
        checkOutput("ferr_set", 32'(bus.frame_err), 32'd1);
        checkOutput("ferr_count", 32'(bus.fifo_count), 32'd0);
        applyStimulus(8'h81, BIT_CLKS, 1'b1, 1'b0, -1);
        tick(4);
        checkOutput("ferr_next_data", 32'(bus.rx_data), 32'h81);
        checkOutput("ferr_next_count", 32'(bus.fifo_count), 32'd1);
        checkOutput("ferr_sticky", 32'(bus.frame_err), 32'd1);
        popOne();
        pulseClear();
        checkOutput("ferr_cleared", 32'(bus.frame_err), 32'd0);

        $display("[TB] rx_enable drop mid-frame");
        applyStimulus(8'hF0, BIT_CLKS, 1'b1, 1'b0, 4);
        rx_enable = 1'b1;
        tick(20);
        checkOutput("abort_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("abort_ferr", 32'(bus.frame_err), 32'd0);
        checkOutput("abort_ovr", 32'(bus.overrun), 32'd0);
        applyStimulus(8'h69, BIT_CLKS, 1'b1, 1'b0, -1);
        tick(4);
        checkOutput("post_abort_data", 32'(bus.rx_data), 32'h69);
        popOne();

        $display("[TB] overrun");
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'(i), BIT_CLKS, 1'b1, 1'b0, -1);
        tick(4);
        checkOutput("full_count", 32'(bus.fifo_count), 32'd16);
        checkOutput("full_no_ovr", 32'(bus.overrun), 32'd0);
        applyStimulus(8'h10, BIT_CLKS, 1'b1, 1'b0, -1);
        tick(4);
        checkOutput("ovr_count", 32'(bus.fifo_count), 32'd16);
        checkOutput("ovr_flag", 32'(bus.overrun), 32'd1);
        checkOutput("ovr_head", 32'(bus.rx_data), 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("drain%0d", i), 32'(bus.rx_data), 32'(i));
            popOne();
        end
        checkOutput("drain_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("drain_ready", 32'(bus.rx_ready), 32'd0);
        popOne();
        checkOutput("pop_empty_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("ovr_sticky", 32'(bus.overrun), 32'd1);
        pulseClear();
        checkOutput("ovr_cleared", 32'(bus.overrun), 32'd0);

        $display("[TB] push+pop while full, clear with push");
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'h40 + 8'(i), BIT_CLKS, 1'b1, 1'b0, -1);
        applyStimulus(8'h50, 14, 1'b1, 1'b0, -1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        checkOutput("pp_count", 32'(bus.fifo_count), 32'd16);
        checkOutput("pp_no_ovr", 32'(bus.overrun), 32'd0);
        checkOutput("pp_head", 32'(bus.rx_data), 32'h41);
        applyStimulus(8'h60, 14, 1'b1, 1'b0, -1);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        checkOutput("clr_push_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("clr_push_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("clr_push_ovr", 32'(bus.overrun), 32'd0);
        tick(5);
        checkOutput("clr_push_lost", 32'(bus.fifo_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
